onehot_decoder_seq: RTL

//   Sequential 3:8 decoder that consumes {index, valid} pairs from the 8:3 priority

---
 rtl/onehot_decoder_seq_if.sv | 25 ++
 rtl/onehot_decoder_seq.sv | 105 ++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq_if.sv
// Handshake and drive bundle for the sequential one-hot decoder.
// The master side supplies indices and abort; the slave side is the decoder.
interface onehot_decoder_seq_if #(
  parameter int IDX_W = 3,
  parameter int N_OUT = 8
);
  logic             in_valid;
  logic [IDX_W-1:0] in_idx;
  logic             in_ready;
  logic             abort;
  logic [N_OUT-1:0] out_onehot;
  logic             out_active;
  logic             done;
  logic             err;

  modport master (
    output in_valid, in_idx, abort,
    input  in_ready, out_onehot, out_active, done, err
  );

  modport slave (
    input  in_valid, in_idx, abort,
    output in_ready, out_onehot, out_active, done, err
  );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Sequential 3:8 style decoder: accepts an index over valid/ready, drives the
// matching one-hot line for HOLD_CYCLES cycles, then inserts one all-zero gap
// cycle flagged by done. Out-of-range indices are rejected with an err pulse,
// and abort cuts a drive short without a done pulse.
module onehot_decoder_seq #(
  parameter int N_OUT       = 8,
  parameter int IDX_W       = 3,
  parameter int HOLD_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  onehot_decoder_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter reload: the last DRIVE cycle is the one that sees cnt == 0.
  localparam logic [7:0]     HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  // One extra bit so N_OUT == 2**IDX_W is representable.
  localparam logic [IDX_W:0] N_OUT_W   = (IDX_W + 1)'(N_OUT);

  state_t           state;
  logic [7:0]       cnt;
  logic [N_OUT-1:0] onehot_q;
  logic             active_q;
  logic             done_q;
  logic             err_q;
  logic             ready_q;

  logic             in_range;
  logic [N_OUT-1:0] decoded;

  assign in_range = ({1'b0, bus.in_idx} < N_OUT_W);
  assign decoded  = N_OUT'(1) << bus.in_idx;

  // Single FSM with all outputs registered; done/err are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      onehot_q <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      // NOTE: pulses default low each cycle; the later assignments in the case
      // override them, which is safe because every assignment here is non-blocking.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (bus.in_valid && ready_q) begin
            if (in_range) begin
              state    <= DRIVE;
              cnt      <= HOLD_LOAD;
              onehot_q <= decoded;
              active_q <= 1'b1;
              ready_q  <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            state    <= IDLE;
            onehot_q <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
          end else if (cnt == 8'd0) begin
            state    <= GAP;
            onehot_q <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          onehot_q <= '0;
          active_q <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_active = active_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
